// File: rtl/mem_pkg.sv
// Shared constants for the two-port RAM arbiter.
// Widths, FSM state encoding and requester port ids.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DP = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and datapath requests.
// MEM_ARB_RR_EN: round-robin via rr_ptr; otherwise DP beats IF.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic if_req,
  input  logic dp_req,
`ifdef MEM_ARB_RR_EN
  input  logic rr_ptr,
`endif
  output logic win
);

  always_comb begin
    win = PORT_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dp_req) win = rr_ptr;
    else if (dp_req)      win = PORT_DP;
`else
    if (dp_req) win = PORT_DP;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: IDLE -> STROBE -> ACK per access.
// Define MEM_ARB_RR_EN for round-robin instead of DP priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dp_req,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_wdata,
  output logic              dp_ack,
  output logic [DATA_W-1:0] dp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dp_rdata_q, dp_rdata_d;
  logic              win;

`ifdef MEM_ARB_RR_EN
  logic rr_q, rr_d;

  mem_arb_pick u_pick (
    .if_req (if_req),
    .dp_req (dp_req),
    .rr_ptr (rr_q),
    .win    (win)
  );
`else
  mem_arb_pick u_pick (
    .if_req (if_req),
    .dp_req (dp_req),
    .win    (win)
  );
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dp_rdata_d = dp_rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_d       = rr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (if_req || dp_req) begin
          state_d = S_STROBE;
          owner_d = win;
`ifdef MEM_ARB_RR_EN
          rr_d    = ~win;
`endif
          if (win == PORT_DP) begin
            we_d    = dp_we;
            addr_d  = dp_addr;
            wdata_d = dp_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
          end
        end
      end
      S_STROBE: begin
        state_d = S_ACK;
        // RAM output settles during the strobe; capture at its end
        if (!we_q) begin
          if (owner_q == PORT_DP) dp_rdata_d = ram_rdata;
          else                    if_rdata_d = ram_rdata;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      owner_q    <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q       <= PORT_IF;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dp_rdata_q <= dp_rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_read  = (state_q == S_STROBE) && !we_q;
  assign ram_write = (state_q == S_STROBE) && we_q;
  assign if_ack    = (state_q == S_ACK) && (owner_q == PORT_IF);
  assign dp_ack    = (state_q == S_ACK) && (owner_q == PORT_DP);
  assign if_rdata  = if_rdata_q;
  assign dp_rdata  = dp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RAM and
// a per-cycle transaction monitor.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dp_req = 1'b0;
  logic        dp_we = 1'b0;
  logic [7:0]  dp_addr = '0;
  logic [31:0] dp_wdata = '0;
  logic        dp_ack;
  logic [31:0] dp_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_write;
  logic        ram_read;
  logic [31:0] ram_rdata = '0;
  logic        busy;

  mem_arbiter dut (
    .clock     (clock),
    .clear     (clear),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dp_req    (dp_req),
    .dp_we     (dp_we),
    .dp_addr   (dp_addr),
    .dp_wdata  (dp_wdata),
    .dp_ack    (dp_ack),
    .dp_rdata  (dp_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_write (ram_write),
    .ram_read  (ram_read),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // edge-triggered RAM
  logic [31:0] mem [256];
  always @(posedge ram_read) begin
    #1;
    ram_rdata = mem[ram_addr];
  end
  always @(posedge ram_write) begin
    #1;
    mem[ram_addr] = ram_wdata;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] data;
  } dp_exp_t;

  logic [31:0] model [256];
  logic [31:0] exp_if [$];
  dp_exp_t     exp_dp [$];
  logic [31:0] dp_last = '0;

  // monitor: every granted access must be strobe then ack
  int          ph = 0;
  logic        pref = 1'b0;
  logic        e_port;
  logic        e_we;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata;
  logic [31:0] prev_if = '0;
  logic [31:0] prev_dp = '0;
  int          grants_if = 0;
  int          grants_dp = 0;
  logic        order [$];

  always @(negedge clock) begin
    if (clear) begin
      ph = 0;
      pref = 1'b0;
      exp_if.delete();
      exp_dp.delete();
      chk("clr_if_rdata", if_rdata, 32'h0);
      chk("clr_dp_rdata", dp_rdata, 32'h0);
      chk("clr_ctl", 32'({busy, ram_read, ram_write, if_ack, dp_ack}), 32'h0);
      prev_if = if_rdata;
      prev_dp = dp_rdata;
    end else begin
      chk("busy", 32'(busy), 32'(ph != 0));
      if (!if_ack) chk("if_rdata_hold", if_rdata, prev_if);
      if (!dp_ack) chk("dp_rdata_hold", dp_rdata, prev_dp);
      case (ph)
        0: begin
          chk("idle_ctl", 32'({ram_read, ram_write, if_ack, dp_ack}), 32'h0);
          if (if_req || dp_req) begin
            if (if_req && dp_req) begin
`ifdef MEM_ARB_RR_EN
              e_port = pref;
`else
              e_port = 1'b1;
`endif
            end else begin
              e_port = dp_req;
            end
            pref = ~e_port;
            order.push_back(e_port);
            if (e_port) begin
              e_we = dp_we;
              e_addr = dp_addr;
              e_wdata = dp_wdata;
            end else begin
              e_we = 1'b0;
              e_addr = if_addr;
            end
            ph = 1;
          end
        end
        1: begin
          chk("strobe", 32'({ram_read, ram_write}), 32'({!e_we, e_we}));
          chk("strobe_addr", 32'(ram_addr), 32'(e_addr));
          if (e_we) chk("strobe_wdata", ram_wdata, e_wdata);
          chk("strobe_acks", 32'({if_ack, dp_ack}), 32'h0);
          ph = 2;
        end
        default: begin
          chk("ack_strobes", 32'({ram_read, ram_write}), 32'h0);
          chk("ack_who", 32'({if_ack, dp_ack}), e_port ? 32'h1 : 32'h2);
          chk("ack_addr", 32'(ram_addr), 32'(e_addr));
          if (!e_port) begin
            grants_if++;
            if (exp_if.size() == 0) chk("if_sb_empty", 32'h1, 32'h0);
            else chk("if_rdata", if_rdata, exp_if.pop_front());
          end else begin
            grants_dp++;
            if (exp_dp.size() == 0) chk("dp_sb_empty", 32'h1, 32'h0);
            else begin
              dp_exp_t e;
              e = exp_dp.pop_front();
              chk(e.we ? "dp_rdata_wr" : "dp_rdata", dp_rdata, e.data);
              if (e.we) chk("ram_written", mem[e_addr], e_wdata);
            end
          end
          ph = 0;
        end
      endcase
      prev_if = if_rdata;
      prev_dp = dp_rdata;
    end
  end

  task automatic if_access(input logic [7:0] a);
    bit got = 0;
    exp_if.push_back(model[a]);
    if_addr = a;
    if_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (if_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("if_ack_timeout", 32'h0, 32'h1);
    if_req = 1'b0;
  endtask

  task automatic dp_access(input logic we, input logic [7:0] a,
                           input logic [31:0] d);
    bit got = 0;
    dp_exp_t e;
    e.we = we;
    if (we) begin
      model[a] = d;
      e.data = dp_last;
    end else begin
      e.data = model[a];
      dp_last = model[a];
    end
    exp_dp.push_back(e);
    dp_we = we;
    dp_addr = a;
    dp_wdata = d;
    dp_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dp_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("dp_ack_timeout", 32'h0, 32'h1);
    dp_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      model[i] = mem[i];
    end
    mem[5] = 32'h12345678;
    model[5] = 32'h12345678;

    #3;
    chk("rst_outs", 32'({busy, ram_read, ram_write, if_ack, dp_ack}), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    @(posedge clock); #1;
    clear = 1'b0;

    @(posedge clock); #1;
    dp_access(1'b1, 8'h10, 32'hDEADBEEF);
    dp_access(1'b0, 8'h10, 32'h0);
    @(posedge clock); #1;
    if_access(8'h05);

    // clear while the read strobe is high
    @(posedge clock); #1;
    exp_dp.push_back('{we: 1'b0, data: model[8'h20]});
    dp_we = 1'b0;
    dp_addr = 8'h20;
    dp_req = 1'b1;
    @(posedge clock); #1;
    chk("pre_clear_read", 32'(ram_read), 32'h1);
    clear = 1'b1;
    #1;
    chk("clear_ctl", 32'({busy, ram_read, ram_write, if_ack, dp_ack}), 32'h0);
    chk("clear_addr", 32'(ram_addr), 32'h0);
    chk("clear_if_rdata", if_rdata, 32'h0);
    chk("clear_dp_rdata", dp_rdata, 32'h0);
    dp_req = 1'b0;
    dp_last = '0;
    @(posedge clock); #1;
    clear = 1'b0;
    dp_access(1'b0, 8'h10, 32'h0);
    chk("post_clear_data", dp_rdata, 32'hDEADBEEF);

    // simultaneous requests
    @(posedge clock); #1;
    order.delete();
    fork
      if_access(8'h06);
      dp_access(1'b0, 8'h07, 32'h0);
    join
`ifdef MEM_ARB_RR_EN
    chk("contend_first", 32'(order[0]), 32'h0);
`else
    chk("contend_first", 32'(order[0]), 32'h1);
`endif

    // both held for four accesses
    @(posedge clock); #1;
    order.delete();
    fork
      begin
        if_access(8'h08);
        if_access(8'h09);
      end
      begin
        dp_access(1'b0, 8'h0A, 32'h0);
        dp_access(1'b0, 8'h0B, 32'h0);
      end
    join
`ifdef MEM_ARB_RR_EN
    chk("rr_order", 32'({order[0], order[1], order[2], order[3]}), 32'b0101);
`else
    chk("fixed_order", 32'({order[0], order[1], order[2], order[3]}), 32'b1100);
`endif

    @(posedge clock); #1;
    dp_access(1'b0, 8'h01, 32'h0);
    dp_access(1'b0, 8'h02, 32'h0);

    // random concurrent traffic in disjoint regions
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
        if_access(8'($urandom_range(128, 255)));
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1;
        dp_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)),
                  $urandom);
      end
    join

    repeat (5) @(posedge clock);
    chk("sb_drained", 32'(exp_if.size() + exp_dp.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
